// File: rtl/pwm_pulse_stage_pkg.sv
// Shared PWM constants and the duty clamp used by the pulse stage and the
// waveform generators feeding it.
package pwm_pkg;

   localparam int PWM_BITS   = 6;
   localparam int DUTY_BITS  = 7;
   localparam int PWM_PERIOD = 64;
   localparam logic [DUTY_BITS-1:0] DUTY_FULL = 7'd64;

   typedef logic [PWM_BITS-1:0]  pwm_cnt_t;
   typedef logic [DUTY_BITS-1:0] duty_t;

   // Anything above a full period of counts saturates to 100 % high.
   function automatic duty_t clamp_duty(input duty_t d);
      return (d > DUTY_FULL) ? DUTY_FULL : d;
   endfunction

endpackage

// File: rtl/pwm_pulse_stage_if.sv
// Duty request / PWM result bundle between a waveform generator (master)
// and the pulse stage (slave).
interface pwm_pulse_stage_if;
   import pwm_pkg::*;

   logic  Enable;
   duty_t Duty_Input;
   logic  Pwm_Out;
   logic  Period_Start;
   duty_t Duty_Applied;

   modport master (
      output Enable,
      output Duty_Input,
      input  Pwm_Out,
      input  Period_Start,
      input  Duty_Applied
   );

   modport slave (
      input  Enable,
      input  Duty_Input,
      output Pwm_Out,
      output Period_Start,
      output Duty_Applied
   );

endinterface

// File: rtl/pwm_pulse_stage_prescaler.sv
// Timebase divider: tick is high one sysclk cycle in every PRESCALE.
// With PRESCALE=1 the counter never leaves 0, so tick is constantly high.
module pwm_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic sysclk,
   input  logic reset,
   output logic tick
);

   localparam logic [7:0] LAST = 8'(PRESCALE - 1);

   logic [7:0] r_pre_cnt;
   logic       w_last;

   assign w_last = (r_pre_cnt == LAST);
   assign tick   = w_last;

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_pre_cnt <= 8'd0;
      end else if (w_last) begin
         r_pre_cnt <= 8'd0;
      end else begin
         r_pre_cnt <= r_pre_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/pwm_pulse_stage.sv
// 64-count PWM pulse stage: duty latched at period boundaries with optional
// slew limiting, registered output and period-start strobe.
module pwm_pulse_stage
   import pwm_pkg::*;
#(
   parameter int PRESCALE  = 1,
   parameter int SLEW_STEP = 64
) (
   input  logic               sysclk,
   input  logic               reset,
   pwm_pulse_stage_if.slave   bus
);

   localparam logic [7:0]           SLEW8 = 8'(SLEW_STEP);
   localparam logic [DUTY_BITS-1:0] SLEW7 = DUTY_BITS'(SLEW_STEP);

   logic     w_tick;
   logic     w_boundary;
   duty_t    w_target;
   logic [7:0] w_diff;
   logic     w_rising;
   duty_t    w_duty_next;

   pwm_cnt_t r_pwm_cnt;
   duty_t    r_duty;
   logic     r_pwm_out;
   logic     r_period_start;

   pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .sysclk (sysclk),
      .reset  (reset),
      .tick   (w_tick)
   );

   assign w_boundary = w_tick && (r_pwm_cnt == '1);
   assign w_target   = bus.Enable ? clamp_duty(bus.Duty_Input) : '0;
   assign w_rising   = (w_target >= r_duty);

   // Step toward the target by at most SLEW_STEP; disable bypasses the ramp.
   // Overshoot is impossible since a full step is only taken when the gap exceeds it.
   always_comb begin
      w_diff      = 8'd0;
      w_duty_next = r_duty;
      if (!bus.Enable) begin
         w_duty_next = '0;
      end else if (w_rising) begin
         w_diff      = {1'b0, w_target} - {1'b0, r_duty};
         w_duty_next = (w_diff <= SLEW8) ? w_target : (r_duty + SLEW7);
      end else begin
         w_diff      = {1'b0, r_duty} - {1'b0, w_target};
         w_duty_next = (w_diff <= SLEW8) ? w_target : (r_duty - SLEW7);
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_pwm_cnt <= '0;
      end else if (w_tick) begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_duty <= '0;
      end else if (w_boundary) begin
         r_duty <= w_duty_next;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_pwm_out      <= 1'b0;
         r_period_start <= 1'b0;
      end else begin
         r_pwm_out      <= bus.Enable && ({1'b0, r_pwm_cnt} < r_duty);
         r_period_start <= w_boundary;
      end
   end

   assign bus.Pwm_Out      = r_pwm_out;
   assign bus.Period_Start = r_period_start;
   assign bus.Duty_Applied = r_duty;

endmodule

// File: doc/pwm_pulse_stage.md
# pwm_pulse_stage

Pulse-determination stage directly downstream of the waveform generators (squarewave and siblings). Consumes a 7-bit duty word in the range 0..64 and produces a single-bit PWM output with a 64-count period. Duty is latched only at period boundaries, optionally slew-limited, and clamped so that 64 means 100 % high. Provides a period-start strobe and the applied duty value for upstream pacing and debug.

## Interface
- PRESCALE, 1: sysclk cycles per PWM count; legal range 1..255.
- SLEW_STEP, 64: maximum change of applied duty per period; legal range 1..64; 64 means no limit.
- sysclk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- Enable  in  1  level; 0 forces the output low and applied duty to 0.
- Duty_Input  in  7  requested duty in counts, 0..64; values above 64 are clamped to 64.
- Pwm_Out  out  1  registered PWM output.
- Period_Start  out  1  one-cycle strobe marking the first cycle of each period.
- Duty_Applied  out  7  duty currently in effect, 0..64.

## Operation
- Prescaler pre_cnt counts 0..PRESCALE-1. tick=1 when pre_cnt==PRESCALE-1. With PRESCALE=1, tick is constant 1.
- PWM counter pwm_cnt is 6 bits, 0..63. It increments on tick and wraps 63→0.
- Boundary event: tick && pwm_cnt==63. Duty_Applied updates only on a boundary event:
  - target = Enable ? min(Duty_Input, 64) : 0.
  - If Enable==0, Duty_Applied ← 0 directly, bypassing slew.
  - Else if |target − Duty_Applied| ≤ SLEW_STEP, Duty_Applied ← target.
  - Else Duty_Applied moves toward target by exactly SLEW_STEP.
  - Arithmetic is 8-bit unsigned internally; no wrap; result is always 0..64.
- Pwm_Out register ← Enable && (pwm_cnt < Duty_Applied), evaluated every cycle from current register values.
  - Duty 64 gives constant high, since pwm_cnt ≤ 63.
  - Duty 0 gives constant low.
- Period_Start register ← (boundary event), so it is high for exactly one cycle: the first cycle in which pwm_cnt==0.
- Duty_Input changes mid-period have no effect until the next boundary. No glitch pulses are allowed.
- Enable falling mid-period: Pwm_Out goes low on the next edge. Counters keep running. Duty_Applied becomes 0 at the next boundary.
- Enable rising: the ramp starts from Duty_Applied (0 if disabled for ≥1 boundary), subject to SLEW_STEP.

## Timing
- Reset values:
  - pre_cnt=0, pwm_cnt=0.
  - Duty_Applied=0, Pwm_Out=0, Period_Start=0.
- After reset release, the first period uses Duty_Applied=0. The first duty update occurs at the first boundary, 64·PRESCALE cycles after reset release.
- Period = 64·PRESCALE sysclk cycles. High time = Duty_Applied·PRESCALE cycles.
- Pwm_Out lags pwm_cnt by 1 cycle. Period_Start is coincident with the first cycle in which pwm_cnt==0.
- Reset asserted mid-period: all state returns to reset values on that edge. Pwm_Out is low from the following cycle.
- Duty_Input sampled only in the cycle of the boundary event. The upstream value may change on any cycle.

## Structure
- Shared package pwm_pkg holds:
  - PWM_BITS=6, DUTY_BITS=7.
  - DUTY_FULL=7'd64, PWM_PERIOD=64.
  - A clamp function for the duty word. The waveform generators import the same constants.
- One sub-module, pwm_prescaler: parameter PRESCALE; ports sysclk, reset, tick. It is reused by other timebase users.
- Top module contains:
  - the pwm_cnt counter;
  - the boundary/slew update logic;
  - the output registers.

## Test plan
- PRESCALE=1, SLEW_STEP=64, Enable=1, Duty_Input=32:
  - First period Pwm_Out is all low.
  - Thereafter 32 high / 32 low per period.
  - Period_Start every 64 cycles.
- Duty_Input=64, then 0, then 100: high for all 64 cycles; low for all 64 cycles; clamped, so all 64 cycles high with Duty_Applied=64.
- SLEW_STEP=8, step Duty_Input 0→40:
  - Duty_Applied sequence over successive boundaries: 8, 16, 24, 32, 40.
  - Then step 40→37: 37 in one boundary.
- Duty_Input toggles 10↔50 every 5 cycles mid-period: high time equals the value present at the preceding boundary; no extra edges.
- PRESCALE=3, Duty=20: period is 192 cycles; high time is 60 cycles; Period_Start every 192 cycles.
- Enable dropped at pwm_cnt=10 with Duty=48:
  - Pwm_Out low from the next cycle.
  - Duty_Applied=0 at the next boundary.
- Reset pulsed at pwm_cnt=30: all outputs at reset values; a fresh 0-duty period follows.
